// File: rtl/shift_chain_pkg.sv
// Shared types and helpers for the shift_chain block: operation modes and
// fill-count width derivation.
package shift_chain_pkg;

  typedef enum logic [1:0] {
    MODE_SHR  = 2'b00,
    MODE_SHL  = 2'b01,
    MODE_LOAD = 2'b10,
    MODE_HOLD = 2'b11
  } mode_t;

  // Fill count must reach DEPTH inclusive, hence DEPTH+1 codes.
  function automatic int unsigned cw_of(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/shift_chain_fill.sv
// Saturating fill counter for shift_chain: clr wins over set_full, which wins
// over inc; full is decoded from the registered count only.
module shift_chain_fill
  import shift_chain_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned CW    = cw_of(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          set_full,
  input  logic          clr,
  output logic [CW-1:0] fill_cnt,
  output logic          full
);

  localparam logic [CW-1:0] FULL_VAL = CW'(DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt <= '0;
    end else if (clr) begin
      fill_cnt <= '0;
    end else if (set_full) begin
      fill_cnt <= FULL_VAL;
    end else if (inc && (fill_cnt != FULL_VAL)) begin
      fill_cnt <= fill_cnt + CW'(1);
    end
  end

  assign full = (fill_cnt == FULL_VAL);

endmodule

// File: rtl/shift_chain.sv
// Multi-tap bidirectional shift register with parallel load, hold, flush and
// fill tracking. Define SHIFT_CHAIN_ROTATE_EN to add the rot port (rotate shifts).
module shift_chain
  import shift_chain_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned CW    = cw_of(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       din,
  input  logic [DEPTH*WIDTH-1:0] pdata,
  input  logic                   flush,
`ifdef SHIFT_CHAIN_ROTATE_EN
  input  logic                   rot,
`endif
  output logic [DEPTH*WIDTH-1:0] taps,
  output logic [WIDTH-1:0]       dout,
  output logic [WIDTH-1:0]       doutf,
  output logic [CW-1:0]          fill_cnt,
  output logic                   full
);

  logic [WIDTH-1:0] stage     [DEPTH];
  logic [WIDTH-1:0] stage_nxt [DEPTH];
  logic             rot_sel;
  logic             inc;
  logic             set_full;

`ifdef SHIFT_CHAIN_ROTATE_EN
  assign rot_sel = rot;
`else
  assign rot_sel = 1'b0;
`endif

  always_comb begin
    stage_nxt = stage;
    inc       = 1'b0;
    set_full  = 1'b0;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) stage_nxt[i] = '0;
    end else if (en) begin
      unique case (mode_t'(mode))
        MODE_SHR: begin
          stage_nxt[0] = rot_sel ? stage[DEPTH-1] : din;
          for (int i = 1; i < DEPTH; i++) stage_nxt[i] = stage[i-1];
          inc = !rot_sel;
        end
        MODE_SHL: begin
          stage_nxt[DEPTH-1] = rot_sel ? stage[0] : din;
          for (int i = 0; i < DEPTH-1; i++) stage_nxt[i] = stage[i+1];
          inc = !rot_sel;
        end
        MODE_LOAD: begin
          for (int i = 0; i < DEPTH; i++) stage_nxt[i] = pdata[i*WIDTH +: WIDTH];
          set_full = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage <= stage_nxt;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_taps
    assign taps[g*WIDTH +: WIDTH] = stage[g];
  end

  assign dout  = stage[DEPTH-1];
  assign doutf = stage[0];

  shift_chain_fill #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fill (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (inc),
    .set_full (set_full),
    .clr      (flush),
    .fill_cnt (fill_cnt),
    .full     (full)
  );

endmodule

// File: tb/tb_shift_chain.sv
// Bench for shift_chain (WIDTH=4, DEPTH=3): directed vector table, reset and
// rotate sequences, then random stimulus against a packed-integer model.
module tb_shift_chain;
  localparam int W  = 4;
  localparam int D  = 3;
  localparam int TW = W * D;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    mode = 2'b11;
  logic [W-1:0]  din = '0;
  logic [TW-1:0] pdata = '0;
  logic          flush = 1'b0;
  logic          rot = 1'b0;
  logic [TW-1:0] taps;
  logic [W-1:0]  dout, doutf;
  logic [1:0]    fill_cnt;
  logic          full;

  int n_vec = 0;
  int n_bad = 0;

  logic [TW-1:0] m_val = '0;
  int            m_cnt = 0;

  always #5 clk = ~clk;

  shift_chain #(.WIDTH(W), .DEPTH(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .din      (din),
    .pdata    (pdata),
    .flush    (flush),
`ifdef SHIFT_CHAIN_ROTATE_EN
    .rot      (rot),
`endif
    .taps     (taps),
    .dout     (dout),
    .doutf    (doutf),
    .fill_cnt (fill_cnt),
    .full     (full)
  );

  typedef struct {
    logic          en;
    logic [1:0]    mode;
    logic [W-1:0]  din;
    logic [TW-1:0] pdata;
    logic          flush;
    logic [TW-1:0] exp_taps;
    int            exp_cnt;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [TW-1:0] et, input int ec);
    logic [TW-1:0] t;
    t = et;
    chk({tag, " taps"}, 32'(taps), 32'(t));
    chk({tag, " dout"}, 32'(dout), 32'(t[TW-1 -: W]));
    chk({tag, " doutf"}, 32'(doutf), 32'(t[W-1:0]));
    chk({tag, " fill_cnt"}, 32'(fill_cnt), 32'(ec));
    chk({tag, " full"}, 32'(full), 32'(ec == D));
  endtask

  // Reference: whole chain as one integer, stage0 in the low bits.
  task automatic model_step();
    logic [TW-1:0] dx;
    dx = TW'(din);
    if (flush) begin
      m_val = '0; m_cnt = 0;
    end else if (en) begin
      case (mode)
        2'b00: begin
          if (rot) m_val = (m_val << W) | (m_val >> (W*(D-1)));
          else begin m_val = (m_val << W) | dx; m_cnt = (m_cnt < D) ? m_cnt + 1 : D; end
        end
        2'b01: begin
          if (rot) m_val = (m_val >> W) | (m_val << (W*(D-1)));
          else begin m_val = (m_val >> W) | (dx << (W*(D-1))); m_cnt = (m_cnt < D) ? m_cnt + 1 : D; end
        end
        2'b10: begin m_val = pdata; m_cnt = D; end
        default: ;
      endcase
    end
  endtask

  task automatic drive(input logic e, input logic [1:0] m, input logic [W-1:0] d,
                       input logic [TW-1:0] p, input logic f, input logic r);
    en = e; mode = m; din = d; pdata = p; flush = f; rot = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 2'b00, 4'h1, 12'h000, 1'b0, 12'h001, 1};
    tbl[1]  = '{1'b1, 2'b00, 4'h2, 12'h000, 1'b0, 12'h012, 2};
    tbl[2]  = '{1'b1, 2'b00, 4'h3, 12'h000, 1'b0, 12'h123, 3};
    tbl[3]  = '{1'b1, 2'b00, 4'h4, 12'h000, 1'b0, 12'h234, 3};
    tbl[4]  = '{1'b1, 2'b10, 4'h0, 12'hABC, 1'b0, 12'hABC, 3};
    tbl[5]  = '{1'b1, 2'b01, 4'hF, 12'h000, 1'b0, 12'hFAB, 3};
    tbl[6]  = '{1'b0, 2'b00, 4'h7, 12'h000, 1'b0, 12'hFAB, 3};
    tbl[7]  = '{1'b0, 2'b00, 4'h7, 12'h000, 1'b0, 12'hFAB, 3};
    tbl[8]  = '{1'b0, 2'b00, 4'h7, 12'h000, 1'b0, 12'hFAB, 3};
    tbl[9]  = '{1'b0, 2'b00, 4'h7, 12'h000, 1'b0, 12'hFAB, 3};
    tbl[10] = '{1'b0, 2'b00, 4'h7, 12'h000, 1'b0, 12'hFAB, 3};
    tbl[11] = '{1'b1, 2'b11, 4'h7, 12'h000, 1'b0, 12'hFAB, 3};
    tbl[12] = '{1'b1, 2'b10, 4'h0, 12'hFFF, 1'b1, 12'h000, 0};
    tbl[13] = '{1'b1, 2'b01, 4'h5, 12'h000, 1'b0, 12'h500, 1};
    tbl[14] = '{1'b0, 2'b00, 4'h9, 12'h000, 1'b0, 12'h500, 1};
    tbl[15] = '{1'b1, 2'b00, 4'h6, 12'h000, 1'b0, 12'h006, 2};

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 12'h000, 0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].mode, tbl[i].din, tbl[i].pdata, tbl[i].flush, 1'b0);
      chk_all($sformatf("tbl%0d", i), tbl[i].exp_taps, tbl[i].exp_cnt);
    end

    // Asynchronous reset mid-cycle with the chain loaded.
    drive(1'b1, 2'b10, 4'h0, 12'h321, 1'b0, 1'b0);
    chk_all("preload", 12'h321, 3);
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 12'h000, 0);
    #1 rst_n = 1'b1;
    drive(1'b1, 2'b00, 4'h7, 12'h000, 1'b0, 1'b0);
    chk_all("post_rst", 12'h007, 1);

`ifdef SHIFT_CHAIN_ROTATE_EN
    drive(1'b1, 2'b10, 4'h0, 12'h321, 1'b0, 1'b0);
    drive(1'b1, 2'b01, 4'h0, 12'h000, 1'b1, 1'b0);
    chk_all("flush_rot", 12'h000, 0);
    drive(1'b1, 2'b10, 4'h0, 12'h321, 1'b0, 1'b0);
    drive(1'b1, 2'b00, 4'h9, 12'h000, 1'b0, 1'b1);
    chk_all("rot_shr", 12'h213, 3);
    drive(1'b1, 2'b01, 4'h9, 12'h000, 1'b0, 1'b1);
    chk_all("rot_shl", 12'h321, 3);
    drive(1'b1, 2'b00, 4'h9, 12'h000, 1'b1, 1'b0);
    drive(1'b1, 2'b00, 4'h4, 12'h000, 1'b0, 1'b1);
    chk_all("rot_cnt", 12'h000, 0);
`endif

    // Random phase; sync the model to the current DUT-independent state.
    drive(1'b1, 2'b00, 4'h0, 12'h000, 1'b1, 1'b0);
    m_val = '0; m_cnt = 0;
    for (int k = 0; k < 400; k++) begin
      en    = ($urandom_range(3) != 0);
      mode  = 2'($urandom_range(3));
      din   = W'($urandom);
      pdata = TW'($urandom);
      flush = ($urandom_range(19) == 0);
`ifdef SHIFT_CHAIN_ROTATE_EN
      rot   = ($urandom_range(3) == 0);
`else
      rot   = 1'b0;
`endif
      model_step();
      @(posedge clk);
      #1;
      chk_all($sformatf("rnd%0d", k), m_val, m_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
